dmem_port_arbiter: RTL and testbench

- Shares the single-port data memory (1024 x 32, word-addressed) between two requesters:
  - the CPU load/store port (port 0);
  - the debug/loader port (port 1), used to preload and inspect data memory without hierarchical pokes.
- Arbitration is fixed-priority to the CPU, with a starvation guard for the debug port.
- Every transaction sees a registered memory command and a routed, one-cycle response pulse.
- Sits between the execute/memory stage, the debug loader and the data memory instance.

---
 rtl/mips32_pkg.sv | 18 +
 rtl/dmem_port_arbiter_if.sv | 50 +++++
 rtl/dmem_arb_prio.sv | 42 ++++
 rtl/dmem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared types for the data-memory port arbiter: memory geometry, arbiter FSM states and owner tags.
package mips32_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } arb_owner_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundles the CPU, debug and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dmem_port_arbiter_if
    import mips32_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();

    logic              cpu_valid;
    logic              cpu_ready;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rsp_valid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_valid;
    logic              dbg_ready;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_rsp_valid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rsp_valid, cpu_rdata,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rsp_valid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rsp_valid, cpu_rdata,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rsp_valid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_prio.sv
// CPU-first grant logic with a debug starvation guard; readys are combinational, same cycle.
// Debug is force-granted once it has lost MAX_WAIT consecutive arbitration slots.
module dmem_arb_prio
    import mips32_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk_x,
    input  logic       rst,
    input  logic       arb_en,
    input  logic       cpu_valid,
    input  logic       dbg_valid,
    output logic       cpu_ready,
    output logic       dbg_ready,
    output arb_owner_t grant_owner
);

    logic [3:0] wait_cnt;
    logic       force_dbg;

    assign force_dbg = (wait_cnt == 4'(MAX_WAIT));

    always_comb begin
        cpu_ready   = arb_en && cpu_valid && !force_dbg;
        dbg_ready   = arb_en && dbg_valid && (!cpu_valid || force_dbg);
        grant_owner = dbg_ready ? OWN_DBG : OWN_CPU;
    end

    // Counts only slots the debug port actually lost; frozen while a command is in ISSUE.
    always_ff @(posedge clk_x or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (arb_en) begin
            if (!dbg_valid || dbg_ready) begin
                wait_cnt <= '0;
            end else if (cpu_ready && !force_dbg) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between CPU and debug ports; accept-to-response is 2 cycles.
// Requests stall (ready low) during ISSUE; a new grant may overlap the previous RESP cycle.
module dmem_port_arbiter
    import mips32_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk_x,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus
);

    arb_state_t        state;
    arb_owner_t        owner;
    arb_owner_t        grant_owner;
    logic              txn_we;
    logic              arb_en;
    logic              grant;
    logic              cpu_ready;
    logic              dbg_ready;
    logic              cpu_rsp_q;
    logic              dbg_rsp_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [DATA_W-1:0] rsp_data;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign arb_en = (state != ISSUE) && !rst;
    assign grant  = cpu_ready || dbg_ready;

    dmem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk_x       (clk_x),
        .rst         (rst),
        .arb_en      (arb_en),
        .cpu_valid   (bus.cpu_valid),
        .dbg_valid   (bus.dbg_valid),
        .cpu_ready   (cpu_ready),
        .dbg_ready   (dbg_ready),
        .grant_owner (grant_owner)
    );

    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (grant_owner == OWN_DBG) begin
            sel_we    = bus.dbg_we;
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
        end
    end

    // Memory read data lands in RESP, so the response data is muxed live rather than registered.
    assign rsp_data = txn_we ? '0 : bus.mem_rdata;

    assign bus.cpu_ready     = cpu_ready;
    assign bus.dbg_ready     = dbg_ready;
    assign bus.cpu_rsp_valid = cpu_rsp_q;
    assign bus.dbg_rsp_valid = dbg_rsp_q;
    assign bus.cpu_rdata     = cpu_rsp_q ? rsp_data : cpu_rdata_q;
    assign bus.dbg_rdata     = dbg_rsp_q ? rsp_data : dbg_rdata_q;

    always_ff @(posedge clk_x or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_CPU;
            txn_we        <= 1'b0;
            cpu_rsp_q     <= 1'b0;
            dbg_rsp_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            dbg_rdata_q   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            cpu_rsp_q  <= 1'b0;
            dbg_rsp_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= RESP;
                    if (owner == OWN_CPU) begin
                        cpu_rsp_q <= 1'b1;
                    end else begin
                        dbg_rsp_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (owner == OWN_CPU) begin
                        cpu_rdata_q <= rsp_data;
                    end else begin
                        dbg_rdata_q <= rsp_data;
                    end
                    state <= grant ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase

            // grant is only possible in IDLE or RESP, since both readys are masked in ISSUE.
            if (grant) begin
                bus.mem_en    <= 1'b1;
                bus.mem_we    <= sel_we;
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
                owner         <= grant_owner;
                txn_we        <= sel_we;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a behavioural memory plus a per-cycle reference model
// of the arbitration rules, with literal expectations at the key points of each scenario.
module tb_dmem_port_arbiter;
    import mips32_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk_x = 1'b0;
    logic rst   = 1'b1;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    int   rst_pulses = 0;

    always #5 clk_x = ~clk_x;
    always @(posedge clk_x) cyc <= cyc + 1;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk_x (clk_x),
        .rst   (rst),
        .bus   (bus)
    );

    // Synchronous single-port data memory.
    logic [DW-1:0] tbmem [1024];
    always @(posedge clk_x) begin
        if (bus.mem_en) begin
            if (bus.mem_we) tbmem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= tbmem[bus.mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference model: transaction granted last cycle (issue) and two cycles ago (resp).
    typedef struct {
        bit            vld;
        bit            dbg;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    initial begin : model
        txn_t          issue_t, resp_t;
        int            losses;
        int            seen_pulses;
        logic [DW-1:0] held_c, held_d;
        logic [DW-1:0] ref_mem [1024];
        bit            can, e_cr, e_dr;
        issue_t = '{default: 0};
        resp_t  = '{default: 0};
        losses = 0; seen_pulses = 0; held_c = '0; held_d = '0;
        forever begin
            @(negedge clk_x);
            if (rst || seen_pulses != rst_pulses) begin
                issue_t = '{default: 0};
                resp_t  = '{default: 0};
                losses = 0; held_c = '0; held_d = '0;
                seen_pulses = rst_pulses;
            end
            if (rst) begin
                chk("rst_cpu_ready", 32'(bus.cpu_ready), 0);
                chk("rst_dbg_ready", 32'(bus.dbg_ready), 0);
                chk("rst_mem_en", 32'(bus.mem_en), 0);
                chk("rst_cpu_rsp", 32'(bus.cpu_rsp_valid), 0);
                chk("rst_dbg_rsp", 32'(bus.dbg_rsp_valid), 0);
                chk("rst_cpu_rdata", bus.cpu_rdata, 0);
                chk("rst_dbg_rdata", bus.dbg_rdata, 0);
            end else begin
                can  = !issue_t.vld;
                e_cr = can && bus.cpu_valid && (losses < MW);
                e_dr = can && bus.dbg_valid && (!bus.cpu_valid || losses == MW);
                chk("cpu_ready", 32'(bus.cpu_ready), 32'(e_cr));
                chk("dbg_ready", 32'(bus.dbg_ready), 32'(e_dr));

                chk("mem_en", 32'(bus.mem_en), 32'(issue_t.vld));
                if (issue_t.vld) begin
                    chk("mem_we", 32'(bus.mem_we), 32'(issue_t.we));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(issue_t.addr));
                    if (issue_t.we) begin
                        chk("mem_wdata", bus.mem_wdata, issue_t.wdata);
                        ref_mem[issue_t.addr] = issue_t.wdata;
                        issue_t.rdata = '0;
                    end else begin
                        issue_t.rdata = ref_mem[issue_t.addr];
                    end
                end else begin
                    chk("mem_we_idle", 32'(bus.mem_we), 0);
                end

                chk("cpu_rsp_valid", 32'(bus.cpu_rsp_valid), 32'(resp_t.vld && !resp_t.dbg));
                chk("dbg_rsp_valid", 32'(bus.dbg_rsp_valid), 32'(resp_t.vld && resp_t.dbg));
                if (resp_t.vld && resp_t.dbg)  held_d = resp_t.rdata;
                if (resp_t.vld && !resp_t.dbg) held_c = resp_t.rdata;
                chk("cpu_rdata", bus.cpu_rdata, held_c);
                chk("dbg_rdata", bus.dbg_rdata, held_d);

                if (can) begin
                    if (!bus.dbg_valid || e_dr)  losses = 0;
                    else if (e_cr && losses < MW) losses++;
                end
                resp_t = issue_t;
                issue_t = '{default: 0};
                if (e_cr || e_dr) begin
                    issue_t.vld   = 1'b1;
                    issue_t.dbg   = e_dr;
                    issue_t.we    = e_dr ? bus.dbg_we    : bus.cpu_we;
                    issue_t.addr  = e_dr ? bus.dbg_addr  : bus.cpu_addr;
                    issue_t.wdata = e_dr ? bus.dbg_wdata : bus.cpu_wdata;
                end
            end
        end
    end

    task automatic align();
        @(posedge clk_x);
        #1;
    endtask

    task automatic cpu_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int acc);
        bus.cpu_valid = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        acc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_x);
            if (bus.cpu_ready) begin acc = cyc; break; end
        end
        align();
        bus.cpu_valid = 1'b0;
        chk("cpu_accept_timeout", 32'(acc < 0), 0);
    endtask

    task automatic dbg_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int acc);
        bus.dbg_valid = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
        acc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_x);
            if (bus.dbg_ready) begin acc = cyc; break; end
        end
        align();
        bus.dbg_valid = 1'b0;
        chk("dbg_accept_timeout", 32'(acc < 0), 0);
    endtask

    task automatic count_slots(output int slot);
        bit found = 0;
        slot = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_x);
            if (bus.cpu_ready || bus.dbg_ready) slot++;
            if (bus.dbg_ready) begin found = 1; break; end
        end
        if (!found) slot = -1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int cc, dc, slot;
        bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'd5; bus.cpu_wdata = 32'h0BADF00D;
        bus.dbg_valid = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 10'd1; bus.dbg_wdata = 32'h12345678;

        // Reset held with both ports requesting.
        repeat (2) begin
            @(negedge clk_x);
            chk("lit_rst_cpu_ready", 32'(bus.cpu_ready), 0);
            chk("lit_rst_dbg_ready", 32'(bus.dbg_ready), 0);
            chk("lit_rst_mem_en", 32'(bus.mem_en), 0);
            chk("lit_rst_mem_addr", 32'(bus.mem_addr), 0);
            chk("lit_rst_mem_wdata", bus.mem_wdata, 0);
            chk("lit_rst_rsp", 32'({bus.cpu_rsp_valid, bus.dbg_rsp_valid}), 0);
        end
        align();
        rst = 1'b0;
        @(negedge clk_x);
        chk("lit_first_cpu_ready", 32'(bus.cpu_ready), 1);
        chk("lit_first_dbg_ready", 32'(bus.dbg_ready), 0);
        cc = cyc;
        align();
        bus.cpu_valid = 1'b0;
        dc = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_x);
            if (bus.dbg_ready) begin dc = cyc; break; end
        end
        align();
        bus.dbg_valid = 1'b0;
        chk("lit_preload_dbg_slot", 32'(dc - cc), 2);
        repeat (3) align();

        // CPU load of the preloaded word.
        cpu_req(1'b0, 10'd1, '0, cc);
        @(negedge clk_x);
        chk("lit_load_mem_en", 32'(bus.mem_en), 1);
        chk("lit_load_mem_addr", 32'(bus.mem_addr), 1);
        @(negedge clk_x);
        chk("lit_load_rsp", 32'(bus.cpu_rsp_valid), 1);
        chk("lit_load_rdata", bus.cpu_rdata, 32'h12345678);
        chk("lit_load_dbg_rsp", 32'(bus.dbg_rsp_valid), 0);
        @(negedge clk_x);
        chk("lit_load_rsp_pulse", 32'(bus.cpu_rsp_valid), 0);
        chk("lit_load_rdata_held", bus.cpu_rdata, 32'h12345678);
        align();

        // CPU store then debug read of the same word.
        cpu_req(1'b1, 10'd3, 32'hDEADBEEF, cc);
        dbg_req(1'b0, 10'd3, '0, dc);
        @(negedge clk_x);
        @(negedge clk_x);
        chk("lit_wr_rd_rsp", 32'(bus.dbg_rsp_valid), 1);
        chk("lit_wr_rd_rdata", bus.dbg_rdata, 32'hDEADBEEF);
        chk("lit_mem_word3", tbmem[3], 32'hDEADBEEF);
        align();

        // Simultaneous requests: CPU first, debug in the RESP slot.
        fork
            cpu_req(1'b0, 10'd3, '0, cc);
            dbg_req(1'b1, 10'd7, 32'hCAFE0007, dc);
        join
        chk("lit_simul_gap", 32'(dc - cc), 2);
        repeat (3) align();

        // Starvation: CPU saturates, debug forced on the MAX_WAIT+1-th slot, twice.
        bus.cpu_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd1;
        bus.dbg_valid = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 10'd7;
        count_slots(slot);
        chk("lit_starve_slot1", 32'(slot), MW + 1);
        align();
        bus.dbg_addr = 10'd5;
        count_slots(slot);
        chk("lit_starve_slot2", 32'(slot), MW + 1);
        align();
        bus.dbg_valid = 1'b0;
        bus.cpu_valid = 1'b0;
        repeat (3) align();

        // Asynchronous reset during ISSUE of a CPU load.
        cpu_req(1'b0, 10'd3, '0, cc);
        #2;
        rst = 1'b1;
        rst_pulses++;
        #1;
        chk("lit_midrst_mem_en", 32'(bus.mem_en), 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk_x);
            chk("lit_midrst_no_rsp", 32'(bus.cpu_rsp_valid), 0);
        end
        align();
        cpu_req(1'b0, 10'd3, '0, cc);
        @(negedge clk_x);
        @(negedge clk_x);
        chk("lit_after_rst_rsp", 32'(bus.cpu_rsp_valid), 1);
        chk("lit_after_rst_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        repeat (3) align();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
